// File: rtl/adc_scan_uart_ctrl_if.sv
// -----------------------------------------------------------------------------
// adc_scan_uart_ctrl_if
// Handshake bundle between the scan controller and its two neighbours:
// the ADC driver (adc_adc128s022) and the byte UART transmitter (uart_byte_tx).
//   adc_start    : controller -> ADC, one-cycle conversion request
//   adc_addr     : controller -> ADC, channel, held from adc_start to adc_done
//   adc_done     : ADC -> controller, one-cycle pulse, adc_data valid
//   adc_data     : ADC -> controller, conversion result (DATA_W bits)
//   uart_en_send : controller -> UART, one-cycle byte start
//   uart_data    : controller -> UART, byte, held until uart_tx_done
//   uart_tx_done : UART -> controller, one-cycle end-of-byte pulse
// Modports: master = controller side, slave = ADC/UART side.
// -----------------------------------------------------------------------------
interface adc_scan_uart_ctrl_if #(
    parameter int DATA_W = 12
);
    logic              adc_start;
    logic [2:0]        adc_addr;
    logic              adc_done;
    logic [DATA_W-1:0] adc_data;
    logic              uart_en_send;
    logic [7:0]        uart_data;
    logic              uart_tx_done;

    modport master (
        output adc_start, adc_addr, uart_en_send, uart_data,
        input  adc_done, adc_data, uart_tx_done
    );

    modport slave (
        input  adc_start, adc_addr, uart_en_send, uart_data,
        output adc_done, adc_data, uart_tx_done
    );
endinterface

// File: rtl/adc_scan_uart_ctrl.sv
// -----------------------------------------------------------------------------
// adc_scan_uart_ctrl
// Scans a masked set of ADC channels on a programmable sample timer, tags each
// result with its channel, buffers {ch, data} in an internal first-word
// fall-through FIFO and sends every entry as a fixed-length byte frame:
//   byte0 = {4'hA, 1'b0, ch}, byte1 = data[DATA_W-1:8] (zero-extended),
//   byte2 = data[7:0], optional byte3 = byte0 ^ byte1 ^ byte2.
// Optional feature macro: CHECKSUM_EN (defined -> 4-byte frame with checksum,
// undefined -> 3-byte frame, no checksum logic).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_start_all   : level, enables periodic scanning
//   i_ch_mask     : channel include mask
//   i_sample_div  : clocks between scan starts (0 or 1 = every cycle)
//   bus           : ADC / UART handshakes (master modport)
//   o_busy        : scan active, FIFO non-empty or frame in flight
//   o_overflow    : sticky sample-dropped flag, cleared on start_all rise
// -----------------------------------------------------------------------------
module adc_scan_uart_ctrl #(
    parameter int NUM_CH     = 8,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_start_all,
    input  logic [NUM_CH-1:0]          i_ch_mask,
    input  logic [DIV_W-1:0]           i_sample_div,
    adc_scan_uart_ctrl_if.master       bus,
    output logic                       o_busy,
    output logic                       o_overflow
);

`ifdef CHECKSUM_EN
    localparam int FRAME_LEN = 4;
`else
    localparam int FRAME_LEN = 3;
`endif
    localparam int EW = 3 + DATA_W;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {A_IDLE, A_SEL, A_START, A_WAIT, A_PUSH} scan_st_t;
    typedef enum logic [1:0] {U_IDLE, U_LOAD, U_SEND, U_WAIT} uart_st_t;

    // Control state
    logic [DIV_W-1:0] r_timer;
    logic             r_start_d;
    scan_st_t         r_scan_st;
    logic [7:0]       r_mask;
    logic [2:0]       r_idx;
    logic [2:0]       r_adc_addr;
    logic             r_overflow;
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    uart_st_t         r_uart_st;
    logic [1:0]       r_b;

    // Datapath storage (no reset needed; always written before being read)
    logic [EW-1:0]    r_sample;
    logic [EW-1:0]    r_mem [FIFO_DEPTH];
    logic [EW-1:0]    r_frame;

    logic             w_tick;
    logic             w_last;
    scan_st_t         w_scan_nx;
    logic [2:0]       w_idx_nx;
    uart_st_t         w_uart_nx;
    logic [1:0]       w_b_nx;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_drop;
    logic             w_pop;

    function automatic logic [7:0] frame_byte(input logic [EW-1:0] ent, input logic [1:0] b);
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        b0 = {4'hA, 1'b0, ent[EW-1 -: 3]};
        b1 = 8'(ent[DATA_W-1:0] >> 8);
        b2 = ent[7:0];
        case (b)
            2'd0:    frame_byte = b0;
            2'd1:    frame_byte = b1;
            2'd2:    frame_byte = b2;
`ifdef CHECKSUM_EN
            2'd3:    frame_byte = b0 ^ b1 ^ b2;
`endif
            default: frame_byte = 8'h00;
        endcase
    endfunction

    // Sample_div of 0 or 1 both mean "tick every cycle".
    assign w_tick = i_start_all &&
                    ((i_sample_div <= DIV_W'(1)) || (r_timer == i_sample_div - DIV_W'(1)));
    assign w_last = (r_idx == 3'(NUM_CH - 1));

    // FIFO flags use the pre-cycle count, so a push into a full FIFO is
    // dropped even if the UART side pops in the same cycle.
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = (r_scan_st == A_PUSH) && !w_full;
    assign w_drop  = (r_scan_st == A_PUSH) && w_full;
    assign w_pop   = (r_uart_st == U_LOAD);

    always_comb begin
        w_scan_nx = r_scan_st;
        w_idx_nx  = r_idx;
        case (r_scan_st)
            A_IDLE: begin
                if (w_tick && (|i_ch_mask)) begin
                    w_scan_nx = A_SEL;
                    w_idx_nx  = 3'd0;
                end
            end
            A_SEL: begin
                // Dropping start_all abandons the channels not yet started.
                if (!i_start_all) begin
                    w_scan_nx = A_IDLE;
                end else if (r_mask[r_idx]) begin
                    w_scan_nx = A_START;
                end else if (w_last) begin
                    w_scan_nx = A_IDLE;
                end else begin
                    w_idx_nx = r_idx + 3'd1;
                end
            end
            A_START: w_scan_nx = A_WAIT;
            A_WAIT: begin
                if (bus.adc_done) w_scan_nx = A_PUSH;
            end
            A_PUSH: begin
                if (w_last || !i_start_all) begin
                    w_scan_nx = A_IDLE;
                end else begin
                    w_scan_nx = A_SEL;
                    w_idx_nx  = r_idx + 3'd1;
                end
            end
            default: w_scan_nx = A_IDLE;
        endcase
    end

    always_comb begin
        w_uart_nx = r_uart_st;
        w_b_nx    = r_b;
        case (r_uart_st)
            U_IDLE: begin
                if (!w_empty) w_uart_nx = U_LOAD;
            end
            U_LOAD: begin
                w_uart_nx = U_SEND;
                w_b_nx    = 2'd0;
            end
            U_SEND: w_uart_nx = U_WAIT;
            U_WAIT: begin
                if (bus.uart_tx_done) begin
                    if (r_b == 2'(FRAME_LEN - 1)) begin
                        w_uart_nx = U_IDLE;
                    end else begin
                        w_uart_nx = U_SEND;
                        w_b_nx    = r_b + 2'd1;
                    end
                end
            end
            default: w_uart_nx = U_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer    <= '0;
            r_start_d  <= 1'b0;
            r_scan_st  <= A_IDLE;
            r_mask     <= '0;
            r_idx      <= '0;
            r_adc_addr <= '0;
            r_overflow <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_uart_st  <= U_IDLE;
            r_b        <= '0;
        end else begin
            r_timer   <= (!i_start_all || w_tick) ? '0 : r_timer + DIV_W'(1);
            r_start_d <= i_start_all;
            r_scan_st <= w_scan_nx;
            r_idx     <= w_idx_nx;
            r_uart_st <= w_uart_nx;
            r_b       <= w_b_nx;

            if (r_scan_st == A_IDLE && w_scan_nx == A_SEL) r_mask <= 8'(i_ch_mask);
            // Address is held from the start pulse until the next start.
            if (r_scan_st == A_SEL && w_scan_nx == A_START) r_adc_addr <= r_idx;

            // A real drop outranks the clear on a simultaneous start_all rise.
            if (w_drop)                          r_overflow <= 1'b1;
            else if (i_start_all && !r_start_d)  r_overflow <= 1'b0;

            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_scan_st == A_WAIT && bus.adc_done) r_sample <= {r_idx, bus.adc_data};
        if (w_push) r_mem[r_wptr] <= r_sample;
        if (w_pop)  r_frame <= r_mem[r_rptr];
    end

    assign bus.adc_start    = (r_scan_st == A_START);
    assign bus.adc_addr     = r_adc_addr;
    assign bus.uart_en_send = (r_uart_st == U_SEND);
    // Gated by state so the byte bus reads 0 whenever no frame is in flight.
    assign bus.uart_data    = (r_uart_st == U_SEND || r_uart_st == U_WAIT) ?
                              frame_byte(r_frame, r_b) : 8'h00;
    assign o_busy     = (r_scan_st != A_IDLE) || !w_empty || (r_uart_st != U_IDLE);
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_adc_scan_uart_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adc_scan_uart_ctrl
// Directed bench for adc_scan_uart_ctrl with behavioural ADC and UART models.
// Models and stimulus act on the falling clock edge; the DUT uses the rising.
// -----------------------------------------------------------------------------
module tb_adc_scan_uart_ctrl;
    localparam int ADC_LAT  = 5;
    localparam int UART_LAT = 6;
`ifdef CHECKSUM_EN
    localparam int FL = 4;
`else
    localparam int FL = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_all = 1'b0;
    logic [7:0]  ch_mask = 8'h00;
    logic [23:0] sample_div = 24'd0;
    logic        busy;
    logic        overflow;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [11:0] adc_val [0:7];
    int          n_start = 0;
    logic [2:0]  addr_log [0:63];
    int          start_cyc [0:63];
    int          n_byte = 0;
    logic [7:0]  byte_log [0:255];
    int          n_done = 0;
    logic        busy_at_done = 1'b0;
    logic        uart_hold = 1'b0;
    logic [7:0]  exp1 [0:7];

    adc_scan_uart_ctrl_if #(.DATA_W(12)) bus ();

    adc_scan_uart_ctrl #(
        .NUM_CH(8), .DATA_W(12), .FIFO_DEPTH(4), .DIV_W(24)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start_all(start_all), .i_ch_mask(ch_mask),
        .i_sample_div(sample_div), .bus(bus), .o_busy(busy), .o_overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        n_start = 0;
        n_byte = 0;
        n_done = 0;
        busy_at_done = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int lim, input string tag);
        int k = 0;
        while (n_byte < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        check({tag, " reached"}, 32'(n_byte >= n), 32'd1);
    endtask

    task automatic wait_starts(input int n, input int lim, input string tag);
        int k = 0;
        while (n_start < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        check({tag, " reached"}, 32'(n_start >= n), 32'd1);
    endtask

    task automatic wait_idle(input int lim, input string tag);
        int k = 0;
        @(negedge clk);
        while (busy && k < lim) begin
            @(negedge clk);
            k++;
        end
        check({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    // ADC driver model: fixed conversion latency, result from adc_val table.
    initial begin
        int         cnt;
        logic [2:0] a;
        bit         pend;
        cnt = 0; a = 3'd0; pend = 1'b0;
        bus.adc_done = 1'b0;
        bus.adc_data = 12'h000;
        forever begin
            @(negedge clk);
            bus.adc_done = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.adc_done = 1'b1;
                        bus.adc_data = adc_val[a];
                        pend = 1'b0;
                    end
                end
                if (bus.adc_start) begin
                    a = bus.adc_addr;
                    pend = 1'b1;
                    cnt = ADC_LAT;
                    if (n_start < 64) begin
                        addr_log[n_start]  = a;
                        start_cyc[n_start] = cyc;
                    end
                    n_start++;
                end
            end
        end
    end

    // UART byte transmitter model: logs bytes, completes after UART_LAT cycles
    // unless uart_hold withholds tx_done.
    initial begin
        int cnt;
        bit pend;
        cnt = 0; pend = 1'b0;
        bus.uart_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.uart_tx_done = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend && !uart_hold) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.uart_tx_done = 1'b1;
                        busy_at_done = busy;
                        n_done++;
                        pend = 1'b0;
                    end
                end
                if (bus.uart_en_send) begin
                    if (n_byte < 256) byte_log[n_byte] = bus.uart_data;
                    n_byte++;
                    pend = 1'b1;
                    cnt = UART_LAT;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        adc_val[0] = 12'h5A3; adc_val[1] = 12'h111; adc_val[2] = 12'h0FF; adc_val[3] = 12'h333;
        adc_val[4] = 12'h444; adc_val[5] = 12'h123; adc_val[6] = 12'h666; adc_val[7] = 12'h777;
`ifdef CHECKSUM_EN
        exp1[0] = 8'hA0; exp1[1] = 8'h05; exp1[2] = 8'hA3; exp1[3] = 8'h06;
        exp1[4] = 8'hA2; exp1[5] = 8'h00; exp1[6] = 8'hFF; exp1[7] = 8'h5D;
`else
        exp1[0] = 8'hA0; exp1[1] = 8'h05; exp1[2] = 8'hA3;
        exp1[3] = 8'hA2; exp1[4] = 8'h00; exp1[5] = 8'hFF;
        exp1[6] = 8'h00; exp1[7] = 8'h00;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst adc_start", 32'(bus.adc_start), 0);
        check("rst adc_addr", 32'(bus.adc_addr), 0);
        check("rst en_send", 32'(bus.uart_en_send), 0);
        check("rst uart_data", 32'(bus.uart_data), 0);
        check("rst busy", 32'(busy), 0);
        check("rst overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: two-channel scan, frame bytes and scan period
        clear_logs();
        ch_mask = 8'h05; sample_div = 24'd1000; start_all = 1'b1;
        wait_bytes(2 * FL, 3000, "t1 bytes");
        check("t1 starts", 32'(n_start), 2);
        check("t1 addr0", 32'(addr_log[0]), 0);
        check("t1 addr1", 32'(addr_log[1]), 2);
        for (int i = 0; i < 2 * FL; i++) check($sformatf("t1 byte%0d", i), 32'(byte_log[i]), 32'(exp1[i]));
        wait_starts(3, 1500, "t1 rescan");
        check("t1 period", 32'(start_cyc[2] - start_cyc[0]), 1000);
        start_all = 1'b0;
        wait_idle(1000, "t1");

        // 2: FIFO fill with UART stalled, overflow set then cleared
        clear_logs();
        uart_hold = 1'b1;
        ch_mask = 8'hFF; sample_div = 24'd0; start_all = 1'b1;
        @(negedge clk);
        check("t2 ovf before", 32'(overflow), 0);
        begin
            int k = 0;
            while (!overflow && k < 500) begin
                @(negedge clk);
                k++;
            end
        end
        check("t2 ovf set", 32'(overflow), 1);
        start_all = 1'b0;
        repeat (30) @(negedge clk);
        check("t2 starts", 32'(n_start), 6);
        check("t2 held bytes", 32'(n_byte), 1);
        uart_hold = 1'b0;
        wait_idle(3000, "t2");
        check("t2 byte count", 32'(n_byte), 32'(5 * FL));
        check("t2 first ch", 32'(byte_log[0]), 32'h0A0);
        check("t2 last ch", 32'(byte_log[4 * FL]), 32'h0A4);
        check("t2 ovf sticky", 32'(overflow), 1);
        ch_mask = 8'h00; start_all = 1'b1;
        repeat (2) @(negedge clk);
        check("t2 ovf cleared", 32'(overflow), 0);
        start_all = 1'b0;
        @(negedge clk);

        // 3: start_all drops while ch3 converts
        clear_logs();
        ch_mask = 8'hFF; sample_div = 24'd0; start_all = 1'b1;
        wait_starts(4, 500, "t3 ch3");
        start_all = 1'b0;
        wait_idle(2000, "t3");
        check("t3 starts", 32'(n_start), 4);
        check("t3 addr3", 32'(addr_log[3]), 3);
        check("t3 byte count", 32'(n_byte), 32'(4 * FL));
        check("t3 ch3 b0", 32'(byte_log[3 * FL]), 32'h0A3);
        check("t3 ch3 b1", 32'(byte_log[3 * FL + 1]), 32'h003);
        check("t3 ch3 b2", 32'(byte_log[3 * FL + 2]), 32'h033);
        check("t3 done count", 32'(n_done), 32'(n_byte));
        check("t3 busy at last done", 32'(busy_at_done), 1);

        // 4: empty mask never starts a conversion
        clear_logs();
        ch_mask = 8'h00; sample_div = 24'd0; start_all = 1'b1;
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 10000; i++) begin
                @(negedge clk);
                seen = seen | busy;
            end
            check("t4 busy seen", 32'(seen), 0);
        end
        check("t4 starts", 32'(n_start), 0);
        start_all = 1'b0;
        @(negedge clk);

        // 5: reset mid-frame
        clear_logs();
        ch_mask = 8'h05; sample_div = 24'd400; start_all = 1'b1;
        wait_bytes(1, 1000, "t5 first byte");
        rst_n = 1'b0;
        #1;
        check("t5 adc_start", 32'(bus.adc_start), 0);
        check("t5 adc_addr", 32'(bus.adc_addr), 0);
        check("t5 en_send", 32'(bus.uart_en_send), 0);
        check("t5 uart_data", 32'(bus.uart_data), 0);
        check("t5 busy", 32'(busy), 0);
        adc_val[0] = 12'hBCD;
        repeat (2) @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
        wait_bytes(2 * FL, 2000, "t5 rescan");
        start_all = 1'b0;
        wait_idle(1000, "t5");
        check("t5 addr0", 32'(addr_log[0]), 0);
        check("t5 b0", 32'(byte_log[0]), 32'h0A0);
        check("t5 b1", 32'(byte_log[1]), 32'h00B);
        check("t5 b2", 32'(byte_log[2]), 32'h0CD);
        check("t5 byte count", 32'(n_byte), 32'(2 * FL));

        // 6: single channel 5 frame (checksum byte when enabled)
        clear_logs();
        ch_mask = 8'h20; sample_div = 24'd50; start_all = 1'b1;
        wait_bytes(FL, 500, "t6 frame");
        start_all = 1'b0;
        check("t6 b0", 32'(byte_log[0]), 32'h0A5);
        check("t6 b1", 32'(byte_log[1]), 32'h001);
        check("t6 b2", 32'(byte_log[2]), 32'h023);
`ifdef CHECKSUM_EN
        check("t6 b3", 32'(byte_log[3]), 32'h087);
`endif
        wait_idle(1000, "t6");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
